// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 mux with manual select and masked channel scan.
// The output beat (sample + channel tag) uses a valid/ready handshake.
module mux_scan_nto1 #(
  parameter int CH      = 8,
  parameter int WIDTH   = 1,
  parameter int SEL_W   = $clog2(CH),
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   data_in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  en,
  input  logic [CH-1:0]         chan_mask,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [WIDTH-1:0]      data_out,
  output logic [SEL_W-1:0]      ch_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // state | meaning
  // IDLE  | no beat held, waiting for a capture condition
  // VALID | beat held on data_out/ch_out until out_ready
  // DWELL | scan gap, counting down before the next scan capture
  typedef enum logic [1:0] {IDLE, VALID, DWELL} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SEL_W-1:0]     ch_q, ch_d;
  logic                 valid_q, valid_d;

  // Wrapping search modulo CH; incl=0 starts one past start and ends on start itself,
  // so a lone enabled channel finds itself again.
  function automatic logic [SEL_W-1:0] find_ch(input logic [SEL_W-1:0] start,
                                               input logic [CH-1:0]    mask,
                                               input logic             incl);
    logic [SEL_W-1:0] res;
    logic [CH-1:0]    sh;
    logic             found;
    int               idx;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < CH; i++) begin
      idx = int'(start) + i + (incl ? 0 : 1);
      if (idx >= CH) idx = idx - CH;
      sh = mask >> idx;
      if (!found && sh[0]) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] pick(input logic [CH*WIDTH-1:0] din,
                                            input logic [SEL_W-1:0]    c);
    logic [CH*WIDTH-1:0] sh;
    sh = din >> (int'(c) * WIDTH);
    return sh[WIDTH-1:0];
  endfunction

  logic             sel_ok, manual_ok, scan_ok, cap;
  logic [SEL_W-1:0] cap_ch, first_ch, adv_ch;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ch_d      = ch_q;
    valid_d   = valid_q;
    cap       = 1'b0;
    cap_ch    = '0;
    sel_ok    = int'(sel) < CH;
    manual_ok = en && !mode && sel_ok;
    scan_ok   = en && mode && (|chan_mask);
    first_ch  = find_ch(ptr_q, chan_mask, 1'b1);
    adv_ch    = find_ch(ptr_q, chan_mask, 1'b0);

    case (state_q)
      IDLE: begin
        if (manual_ok) begin
          cap    = 1'b1;
          cap_ch = sel;
        end else if (scan_ok) begin
          cap    = 1'b1;
          cap_ch = first_ch;
          ptr_d  = first_ch;
        end
      end
      VALID: begin
        if (out_ready) begin
          if (manual_ok) begin
            cap    = 1'b1;
            cap_ch = sel;
          end else if (scan_ok && (dwell == '0)) begin
            cap    = 1'b1;
            cap_ch = adv_ch;
            ptr_d  = adv_ch;
          end else if (scan_ok) begin
            cnt_d   = dwell;
            valid_d = 1'b0;
            state_d = DWELL;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DWELL: begin
        if (!scan_ok) begin
          state_d = IDLE;
        end else if (cnt_q <= DWELL_W'(1)) begin
          cap    = 1'b1;
          cap_ch = adv_ch;
          ptr_d  = adv_ch;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (cap) begin
      data_d  = pick(data_in, cap_ch);
      ch_d    = cap_ch;
      valid_d = 1'b1;
      state_d = VALID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign ch_out    = ch_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Bench for mux_scan_nto1: an 8-channel and a 6-channel instance, 4-bit samples,
// channel k carrying 4'hF-k.
module tb_mux_scan_nto1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a_data;
  logic [2:0]  a_sel, a_ch;
  logic        a_mode, a_en, a_ready, a_valid;
  logic [7:0]  a_mask, a_dwell;
  logic [3:0]  a_dout;

  logic [23:0] b_data;
  logic [2:0]  b_sel, b_ch;
  logic        b_mode, b_en, b_ready, b_valid;
  logic [5:0]  b_mask;
  logic [7:0]  b_dwell;
  logic [3:0]  b_dout;

  mux_scan_nto1 #(.CH(8), .WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_data), .sel(a_sel), .mode(a_mode), .en(a_en),
    .chan_mask(a_mask), .dwell(a_dwell), .data_out(a_dout), .ch_out(a_ch),
    .out_valid(a_valid), .out_ready(a_ready));

  mux_scan_nto1 #(.CH(6), .WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_data), .sel(b_sel), .mode(b_mode), .en(b_en),
    .chan_mask(b_mask), .dwell(b_dwell), .data_out(b_dout), .ch_out(b_ch),
    .out_valid(b_valid), .out_ready(b_ready));

  int checks = 0;
  int failures = 0;
  int xfers = 0;

  always @(posedge clk) if (a_valid && a_ready) xfers++;

  typedef struct {
    logic       mode;
    logic       en;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic       ready;
    logic       v;
    logic [2:0] ch;
    logic [3:0] d;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic mode, input logic en, input logic [7:0] mask,
                              input logic [7:0] dwell, input logic ready, input logic v,
                              input logic [2:0] ch, input logic [3:0] d);
    vec_t r;
    r.mode = mode; r.en = en; r.mask = mask; r.dwell = dwell; r.ready = ready;
    r.v = v; r.ch = ch; r.d = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string n, input logic v, input logic [2:0] c, input logic [3:0] d);
    chk($sformatf("%s.valid", n), 32'(a_valid), 32'(v));
    chk($sformatf("%s.ch", n),    32'(a_ch),    32'(c));
    chk($sformatf("%s.data", n),  32'(a_dout),  32'(d));
  endtask

  task automatic chk_b(input string n, input logic v, input logic [2:0] c, input logic [3:0] d);
    chk($sformatf("%s.valid", n), 32'(b_valid), 32'(v));
    chk($sformatf("%s.ch", n),    32'(b_ch),    32'(c));
    chk($sformatf("%s.data", n),  32'(b_dout),  32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_data();
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = 4'(15 - k);
    return r;
  endfunction

  initial begin
    //             mode en   mask    dwell ready  v  ch  data
    tbl[0]  = mk(1, 0, 8'hA5, 8'd0, 1, 0, 3'd1, 4'hE);
    tbl[1]  = mk(1, 1, 8'hA5, 8'd0, 1, 1, 3'd0, 4'hF);
    tbl[2]  = mk(1, 1, 8'hA5, 8'd0, 1, 1, 3'd2, 4'hD);
    tbl[3]  = mk(1, 1, 8'hA5, 8'd0, 1, 1, 3'd5, 4'hA);
    tbl[4]  = mk(1, 1, 8'hA5, 8'd0, 1, 1, 3'd7, 4'h8);
    tbl[5]  = mk(1, 1, 8'hA5, 8'd0, 1, 1, 3'd0, 4'hF);
    tbl[6]  = mk(1, 1, 8'hA5, 8'd0, 1, 1, 3'd2, 4'hD);
    tbl[7]  = mk(1, 1, 8'hA5, 8'd3, 1, 0, 3'd2, 4'hD);
    tbl[8]  = mk(1, 1, 8'hA5, 8'd3, 1, 0, 3'd2, 4'hD);
    tbl[9]  = mk(1, 1, 8'hA5, 8'd3, 1, 0, 3'd2, 4'hD);
    tbl[10] = mk(1, 1, 8'hA5, 8'd3, 1, 1, 3'd5, 4'hA);
    tbl[11] = mk(1, 1, 8'hA5, 8'd3, 1, 0, 3'd5, 4'hA);
    tbl[12] = mk(1, 1, 8'hA5, 8'd3, 1, 0, 3'd5, 4'hA);
    tbl[13] = mk(1, 1, 8'hA5, 8'd3, 1, 0, 3'd5, 4'hA);
    tbl[14] = mk(1, 1, 8'hA5, 8'd3, 1, 1, 3'd7, 4'h8);
    tbl[15] = mk(1, 1, 8'hA5, 8'd2, 1, 0, 3'd7, 4'h8);
    tbl[16] = mk(1, 0, 8'hA5, 8'd2, 1, 0, 3'd7, 4'h8);
    tbl[17] = mk(1, 0, 8'hA5, 8'd2, 1, 0, 3'd7, 4'h8);
    tbl[18] = mk(1, 0, 8'hA5, 8'd2, 1, 0, 3'd7, 4'h8);
    tbl[19] = mk(1, 1, 8'hA5, 8'd2, 1, 1, 3'd7, 4'h8);
    tbl[20] = mk(1, 1, 8'hA5, 8'd2, 1, 0, 3'd7, 4'h8);
    tbl[21] = mk(1, 1, 8'hA5, 8'd2, 1, 0, 3'd7, 4'h8);
    tbl[22] = mk(1, 1, 8'hA5, 8'd2, 1, 1, 3'd0, 4'hF);

    rst = 1'b1;
    a_data = init_data(); a_sel = 3'd0; a_mode = 1'b1; a_en = 1'b1;
    a_mask = 8'h04; a_dwell = 8'd3; a_ready = 1'b1;
    b_data = a_data[23:0]; b_sel = 3'd0; b_mode = 1'b0; b_en = 1'b0;
    b_mask = 6'd0; b_dwell = 8'd0; b_ready = 1'b1;

    // Reset, then asynchronous reset in the middle of a dwell gap
    tick(); tick();
    chk_a("reset_a", 1'b0, 3'd0, 4'h0);
    chk_b("reset_b", 1'b0, 3'd0, 4'h0);
    rst = 1'b0;
    tick();
    chk_a("pre_dwell_beat", 1'b1, 3'd2, 4'hD);
    tick();
    chk_a("dwell_entry", 1'b0, 3'd2, 4'hD);
    tick();
    #3 rst = 1'b1;
    #1 chk_a("async_reset", 1'b0, 3'd0, 4'h0);
    a_mask = 8'hFF; a_dwell = 8'd0;
    tick();
    rst = 1'b0;
    tick();
    chk_a("first_after_reset", 1'b1, 3'd0, 4'hF);

    // Manual back-to-back beats
    a_mode = 1'b0; a_sel = 3'd3;
    tick();
    chk_a("manual_sel3", 1'b1, 3'd3, 4'hC);
    a_sel = 3'd6;
    tick();
    chk_a("manual_sel6", 1'b1, 3'd6, 4'h9);

    // Backpressure: beat must be held while inputs churn
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_sel  = (i % 2 == 0) ? 3'd1 : 3'd5;
      a_data = $urandom();
      tick();
      chk_a($sformatf("hold[%0d]", i), 1'b1, 3'd6, 4'h9);
    end
    a_data = init_data();
    a_sel  = 3'd1;
    begin
      int x0;
      x0 = xfers;
      a_ready = 1'b1;
      tick();
      chk_a("release_capture", 1'b1, 3'd1, 4'hE);
      chk("release_xfers", 32'(xfers), 32'(x0 + 1));
      a_ready = 1'b0;
      tick();
      chk_a("release_hold", 1'b1, 3'd1, 4'hE);
      chk("release_single_xfer", 32'(xfers), 32'(x0 + 1));
    end

    // Scan sequences, dwell gaps, enable drop with retained pointer
    a_sel = 3'd0;
    for (int i = 0; i < 23; i++) begin
      a_mode = tbl[i].mode; a_en = tbl[i].en; a_mask = tbl[i].mask;
      a_dwell = tbl[i].dwell; a_ready = tbl[i].ready;
      tick();
      chk_a($sformatf("scan[%0d]", i), tbl[i].v, tbl[i].ch, tbl[i].d);
    end

    // Six-channel instance: out-of-range select, empty mask, single channel, wrap
    b_en = 1'b1; b_mode = 1'b0; b_sel = 3'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("b_sel7[%0d]", i), 32'(b_valid), 32'd0);
    end
    b_sel = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("b_sel6[%0d]", i), 32'(b_valid), 32'd0);
    end
    b_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("b_mask0[%0d]", i), 32'(b_valid), 32'd0);
    end
    b_mask = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_b($sformatf("b_single[%0d]", i), 1'b1, 3'd3, 4'hC);
    end
    b_mask = 6'b100001;
    tick(); chk_b("b_wrap0", 1'b1, 3'd5, 4'hA);
    tick(); chk_b("b_wrap1", 1'b1, 3'd0, 4'hF);
    tick(); chk_b("b_wrap2", 1'b1, 3'd5, 4'hA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
Parametrised, registered N-to-1 multiplexer. It is the sequential successor to the fixed 8-to-1 combinational mux. Two modes:
- Manual mode forwards the channel chosen by `sel`.
- Scan mode steps a pointer through a channel-enable mask, with a programmable dwell gap between samples.

The output is a registered beat (data plus channel tag) under a valid/ready handshake. It feeds downstream capture or serialising logic.

Parameters:
- CH, 8, number of input channels (2..256)
- WIDTH, 1, bits per channel
- SEL_W, $clog2(CH), width of `sel`, `ch_out` and the scan pointer
- DWELL_W, 8, width of the dwell count

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  manual-mode channel select
- mode  input  1  0 = manual, 1 = scan
- en  input  1  block enable
- chan_mask  input  CH  scan-mode channel enables; bit k enables channel k
- dwell  input  DWELL_W  idle cycles inserted between scan beats
- data_out  output  WIDTH  registered sample
- ch_out  output  SEL_W  index of the channel sampled into `data_out`
- out_valid  output  1  `data_out` and `ch_out` hold a beat
- out_ready  input  1  downstream accepts; a beat transfers on a cycle with out_valid & out_ready

Behaviour:
- **Reset (rst=1, async):**
  - data_out=0, ch_out=0, out_valid=0.
  - Internal: ptr=0, dwell counter=0, state=IDLE.
  - Takes effect immediately in any state, including mid-beat and mid-dwell.
- **Capture:** one cycle of latency. The capture edge loads data_out = data_in[ch], loads ch_out = ch, and sets out_valid=1.
- **Handshake rule:** while out_valid=1 and out_ready=0, data_out and ch_out are held stable. This holds regardless of changes on data_in, sel, mode, en, chan_mask or dwell.
- **Mode changes:** mode, en, sel and mask are sampled only in IDLE, at handshake completion, and during DWELL.
- **State machine: IDLE, VALID, DWELL.**
- **IDLE** (out_valid=0):
  - If en=1, mode=0 and sel<CH: capture sel, go to VALID.
  - If en=1, mode=1 and chan_mask≠0: capture the first enabled channel at or after ptr (wrapping), set ptr to it, go to VALID.
  - Otherwise stay in IDLE. sel≥CH never captures.
- **VALID** (out_valid=1), on a handshake:
  - Manual mode, en=1, sel<CH: capture sel in the same edge and stay in VALID. This gives back-to-back beats.
  - Scan mode, en=1, mask≠0, dwell=0: advance ptr to the next enabled channel strictly after ptr (wrapping), capture it, stay in VALID.
  - Scan mode, en=1, mask≠0, dwell>0: load counter=dwell, clear out_valid, go to DWELL.
  - Any other condition: clear out_valid, go to IDLE.
- **DWELL** (out_valid=0):
  - The counter decrements each cycle.
  - When the counter reaches 1, the next edge advances ptr to the next enabled channel and captures it, going to VALID.
  - If en=0, mode=0 or mask=0 during DWELL: go to IDLE. ptr is retained.
  - Net effect: exactly `dwell` cycles with out_valid=0 between scan beats, giving a beat period of dwell+1 cycles under ready=1.
- **Scan search:**
  - A single enabled channel repeats every beat.
  - Mask bits for channels ≥CH do not exist.
  - The mask is sampled combinationally at the advance edge.
- **Widths:** ptr wraps modulo CH, not modulo 2^SEL_W. The dwell counter is DWELL_W bits and does not wrap below 0.
- **Outputs when idle:** data_out and ch_out retain their last captured values when out_valid=0.

Test Plan:
Setup for tests 1–4, 6: CH=8, WIDTH=4, data_in channel k = 4'hF-k.

1. **Reset:** assert rst mid-DWELL with out_valid previously 1 → data_out=0, ch_out=0, out_valid=0 in the same cycle without waiting for a clock. Release with mode=1, mask=8'hFF, dwell=0 → first beat ch_out=0, data_out=4'hF.
2. **Manual:** mode=0, en=1, sel=3, out_ready=1 → out_valid=1 one cycle later with data_out=4'hC, ch_out=3. Change sel to 6 → next beat data_out=4'h9, ch_out=6, with no bubble.
3. **Backpressure:** out_ready=0 for 5 cycles while sel toggles 1/5 and data_in changes → data_out and ch_out stay at the first captured values. Raise out_ready → exactly one transfer of that beat, then a new capture.
4. **Scan:** mode=1, chan_mask=8'b1010_0101, dwell=0, out_ready=1 → ch_out sequence 0,2,5,7,0,2 on consecutive cycles with out_valid continuously 1. Then set dwell=3 → beats separated by exactly 3 cycles of out_valid=0, period 4.
5. **Out-of-range / empty mask:** CH=6 instance, mode=0, sel=7 → out_valid stays 0 for 10 cycles. Then mode=1, chan_mask=0 → out_valid stays 0. Then chan_mask=6'b001000 → ch_out=3 on every beat.
6. **Enable drop:** mode=1, dwell=2, deassert en during DWELL → state returns to IDLE and out_valid remains 0. Re-assert en → scan resumes at the first enabled channel at or after the retained ptr.
